// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one CPU access per three cycles,
// commits valid stores at the BUSY->RESP edge and answers with a one-cycle ready pulse.
module dmem_responder #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  memwrite,
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  output logic [63:0] readdata,
  output logic        ready,
  output logic        err,
  output logic [9:0]  wcnt
);

  localparam int          IW    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(8 * DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WORD  = 2'b01,
    OP_DWORD = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  state_t      state;
  op_t         op;
  logic [63:0] adr;
  logic [63:0] wdata;
  logic [63:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic          in_range;
  logic          bad;
  logic          commit;
  logic [63:0]   cur;
  logic [63:0]   nxt;

  // Decode of the latched access; evaluated during BUSY, consumed at the commit edge.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    idx      = adr[3 +: IW];
    cur      = mem[idx];
    in_range = adr < LIMIT;
    bad      = !in_range;
    nxt      = cur;
    case (op)
      OP_WORD:  bad = !in_range || (adr[1:0] != 2'b00);
      OP_DWORD: bad = !in_range || (adr[2:0] != 3'b000);
      OP_RSVD:  bad = 1'b1;
      default:  bad = !in_range;
    endcase
    commit = !bad && ((op == OP_WORD) || (op == OP_DWORD));
    if (op == OP_DWORD) begin
      nxt = wdata;
    end else if (op == OP_WORD) begin
      if (adr[2]) nxt[63:32] = wdata[31:0];
      else        nxt[31:0]  = wdata[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      state    <= IDLE;
      op       <= OP_READ;
      adr      <= '0;
      wdata    <= '0;
      readdata <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      wcnt     <= '0;
      // NOTE: the storage is cleared by reset, so it must live in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready    <= 1'b0;
      err      <= 1'b0;
      readdata <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            op    <= op_t'(memwrite);
            adr   <= dataadr;
            wdata <= writedata;
            state <= BUSY;
          end
        end
        BUSY: begin
          state <= RESP;
          ready <= 1'b1;
          err   <= bad;
          if (commit) begin
            mem[idx] <= nxt;
            if (wcnt != '1) wcnt <= wcnt + 10'd1;
          end
          // Response shows the doubleword as it stands after this edge's commit.
          readdata <= !in_range ? '0 : (commit ? nxt : cur);
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
